// File: rtl/tff_ctrl_pkg.sv
// Shared constants for the T flip-flop bank sequencer.
//   MODE_*  : command codes carried on the mode input alongside start
//   state_t : sequencer states
package tff_ctrl_pkg;

  localparam logic [1:0] MODE_UP  = 2'b00;
  localparam logic [1:0] MODE_DN  = 2'b01;
  localparam logic [1:0] MODE_LD  = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/tff_cell.sv
// One toggle flip-flop of the bank.
//   clk   : clock, state changes on posedge
//   rst_n : synchronous active-low reset (q=0, qbar=1)
//   t     : toggle enable
//   q     : stored bit
//   qbar  : complement of q, kept as its own register
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q,
  output logic qbar
);

  // NOTE: non-blocking assignments make qbar take the pre-edge q, so the
  // pair always stays complementary regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q    <= 1'b0;
      qbar <= 1'b1;
    end else if (t) begin
      q    <= ~q;
      qbar <= q;
    end
  end

endmodule

// File: rtl/tff_counter_ctrl.sv
// Sequencer driving a bank of WIDTH T flip-flops. A start/mode command
// turns into per-bit toggle enables that count up, count down, load a
// value or clear the bank; up/down runs stop at a latched terminal value
// or on stop.
//   clk, rst_n : clock and synchronous active-low reset
//   start      : command strobe, accepted only while idle
//   mode       : 00 up, 01 down, 10 load, 11 clear (sampled with start)
//   load_val   : load target (sampled with start)
//   term_val   : terminal value for up/down (sampled with start)
//   stop       : aborts an up/down run
//   t_vec      : toggle enables to the bank
//   q          : bank state
//   busy       : command in progress (run/load/clear)
//   done       : one-cycle completion pulse
import tff_ctrl_pkg::*;

module tff_counter_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  input  logic             stop,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_t           state, state_next;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] load_r, term_r;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] up_vec, dn_vec;
  logic             accept;
  logic             run_exit;

  assign accept   = (state == ST_IDLE) && start;
  // Hitting the terminal value and stop both end a run in the same way.
  assign run_exit = (q == term_r) || stop;

  // Command registers only move when a command is accepted, so start
  // pulses while busy or in the done cycle leave them untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_r <= MODE_UP;
      load_r <= '0;
      term_r <= '0;
    end else if (accept) begin
      mode_r <= mode;
      load_r <= load_val;
      term_r <= term_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first so every path drives state_next and
    // no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (mode)
            MODE_UP, MODE_DN: state_next = ST_RUN;
            MODE_LD:          state_next = ST_LOAD;
            default:          state_next = ST_CLEAR;
          endcase
        end
      end
      ST_RUN:   if (run_exit) state_next = ST_DONE;
      ST_LOAD:  state_next = ST_DONE;
      ST_CLEAR: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Ripple enables: bit i toggles when every lower bit is 1 (up) or 0
  // (down). The down chain uses the cells' own qbar outputs.
  always_comb begin
    logic up_acc, dn_acc;
    up_vec = '0;
    dn_vec = '0;
    up_acc = 1'b1;
    dn_acc = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_vec[i] = up_acc;
      dn_vec[i] = dn_acc;
      up_acc    = up_acc & q[i];
      dn_acc    = dn_acc & qbar[i];
    end
  end

  always_comb begin
    t_vec = '0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      ST_RUN: begin
        busy = 1'b1;
        if (!run_exit) t_vec = (mode_r == MODE_DN) ? dn_vec : up_vec;
      end
      ST_LOAD: begin
        busy  = 1'b1;
        t_vec = q ^ load_r;  // flip exactly the bits that differ
      end
      ST_CLEAR: begin
        busy  = 1'b1;
        t_vec = q;           // flip every bit that is set
      end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    tff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (t_vec[i]),
      .q     (q[i]),
      .qbar  (qbar[i])
    );
  end

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Self-checking bench for tff_counter_ctrl (WIDTH=8). A behavioural model
// tracks the bank value as an integer and the command phase; the expected
// toggle vector is the XOR of the current and next model value.
module tb_tff_counter_ctrl;

  typedef enum int {P_IDLE, P_RUN, P_LOAD, P_CLEAR, P_DONE} phase_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic [7:0] load_val;
  logic [7:0] term_val;
  logic       stop;
  logic [7:0] t_vec;
  logic [7:0] q;
  logic       busy;
  logic       done;

  int compared   = 0;
  int mismatched = 0;

  phase_t     m_phase;
  logic [7:0] m_q, m_load, m_term;
  logic       m_dn;

  logic [7:0] obs_q, obs_tvec;
  logic       obs_busy, obs_done;
  int         done_seen;

  tff_counter_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .load_val (load_val),
    .term_val (term_val),
    .stop     (stop),
    .t_vec    (t_vec),
    .q        (q),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not finish (compared %0d)", compared);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_q     = 8'h00;
    m_load  = 8'h00;
    m_term  = 8'h00;
    m_dn    = 1'b0;
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle against the
  // model, then advance the model across the posedge.
  task automatic tick(input logic st, input logic [1:0] md, input logic [7:0] lv,
                      input logic [7:0] tv, input logic sp);
    logic [7:0] nq;
    phase_t     nph;
    start = st; mode = md; load_val = lv; term_val = tv; stop = sp;
    nq  = m_q;
    nph = m_phase;
    case (m_phase)
      P_IDLE:  if (st) nph = (md == 2'b10) ? P_LOAD : (md == 2'b11) ? P_CLEAR : P_RUN;
      P_RUN: begin
        if (m_q == m_term || sp) nph = P_DONE;
        else                     nq  = m_dn ? m_q - 8'd1 : m_q + 8'd1;
      end
      P_LOAD:  begin nq = m_load; nph = P_DONE; end
      P_CLEAR: begin nq = 8'h00;  nph = P_DONE; end
      default: nph = P_IDLE;
    endcase
    @(negedge clk);
    obs_q = q; obs_tvec = t_vec; obs_busy = busy; obs_done = done;
    if (done === 1'b1) done_seen++;
    check("q", q, m_q);
    check("t_vec", t_vec, nq ^ m_q);
    check("busy", busy, m_phase inside {P_RUN, P_LOAD, P_CLEAR});
    check("done", done, m_phase == P_DONE);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_phase == P_IDLE && st) begin
        m_dn = (md == 2'b01); m_load = lv; m_term = tv;
      end
      m_q     = nq;
      m_phase = nph;
    end
  endtask

  task automatic idle_tick();
    tick(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
  endtask

  // Issue a command and idle until the model is back in idle.
  task automatic cmd(input logic [1:0] md, input logic [7:0] lv, input logic [7:0] tv);
    tick(1'b1, md, lv, tv, 1'b0);
    for (int k = 0; k < 600; k++) begin
      if (m_phase == P_IDLE) break;
      idle_tick();
    end
    check("cmd_budget", m_phase == P_IDLE, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; load_val = 8'h00; term_val = 8'h00; stop = 1'b0;
    done_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Reset state
    idle_tick();
    check("rst_q", obs_q, 8'h00);
    check("rst_tvec", obs_tvec, 8'h00);
    check("rst_busy", obs_busy, 1'b0);
    check("rst_done", obs_done, 1'b0);

    // Reset in the middle of an up run from 0x37
    cmd(2'b10, 8'h37, 8'h00);
    tick(1'b1, 2'b00, 8'h00, 8'h80, 1'b0);
    idle_tick();
    rst_n = 1'b0;
    idle_tick();
    idle_tick();
    check("mid_rst_q", obs_q, 8'h00);
    check("mid_rst_tvec", obs_tvec, 8'h00);
    check("mid_rst_busy", obs_busy, 1'b0);
    check("mid_rst_done", obs_done, 1'b0);
    rst_n = 1'b1;
    idle_tick();

    // Up run 0 -> 5: latency and single done pulse
    cmd(2'b11, 8'h00, 8'h00);
    tick(1'b1, 2'b00, 8'h00, 8'h05, 1'b0);
    done_seen = 0;
    for (int k = 0; k < 5; k++) begin
      idle_tick();
      check("up_q", obs_q, k);
    end
    idle_tick();
    check("up_term_q", obs_q, 8'h05);
    check("up_term_tvec", obs_tvec, 8'h00);
    check("up_term_done", obs_done, 1'b0);
    idle_tick();
    check("up_done", obs_done, 1'b1);
    idle_tick();
    check("up_idle_busy", obs_busy, 1'b0);
    check("up_done_count", done_seen, 1);

    // Load 0x3C -> 0xA5
    cmd(2'b10, 8'h3C, 8'h00);
    tick(1'b1, 2'b10, 8'hA5, 8'h00, 1'b0);
    idle_tick();
    check("ld_tvec", obs_tvec, 8'h99);
    check("ld_busy", obs_busy, 1'b1);
    idle_tick();
    check("ld_q", obs_q, 8'hA5);
    check("ld_done", obs_done, 1'b1);
    check("ld_busy_off", obs_busy, 1'b0);

    // Down run 0x01 -> 0xFE with wrap
    cmd(2'b10, 8'h01, 8'h00);
    tick(1'b1, 2'b01, 8'h00, 8'hFE, 1'b0);
    done_seen = 0;
    idle_tick(); check("dn_q0", obs_q, 8'h01);
    idle_tick(); check("dn_q1", obs_q, 8'h00);
    idle_tick(); check("dn_q2", obs_q, 8'hFF);
    idle_tick(); check("dn_q3", obs_q, 8'hFE);
    idle_tick(); check("dn_done", obs_done, 1'b1);
    idle_tick();
    check("dn_done_count", done_seen, 1);

    // Up run aborted by stop at 0x04, with start pulses while busy
    cmd(2'b11, 8'h00, 8'h00);
    tick(1'b1, 2'b00, 8'h00, 8'hFF, 1'b0);
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (m_q == 8'h04) break;
      tick(1'b1, 2'b00, 8'h00, 8'h02, 1'b0);
    end
    tick(1'b1, 2'b11, 8'h00, 8'h02, 1'b1);
    check("stop_q", obs_q, 8'h04);
    check("stop_tvec", obs_tvec, 8'h00);
    tick(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
    check("stop_done", obs_done, 1'b1);
    idle_tick();
    check("stop_hold_q", obs_q, 8'h04);
    check("stop_done_count", done_seen, 1);

    // Clear 0xC3, start in the done cycle is ignored
    cmd(2'b10, 8'hC3, 8'h00);
    tick(1'b1, 2'b11, 8'h00, 8'h00, 1'b0);
    idle_tick();
    check("clr_tvec", obs_tvec, 8'hC3);
    tick(1'b1, 2'b00, 8'h00, 8'h10, 1'b0);
    check("clr_done", obs_done, 1'b1);
    check("clr_q", obs_q, 8'h00);
    idle_tick();
    check("clr_ignore_busy", obs_busy, 1'b0);
    check("clr_ignore_tvec", obs_tvec, 8'h00);

    // Randomized commands with stray start/stop and occasional reset
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        idle_tick();
        rst_n = 1'b1;
        idle_tick();
      end else begin
        logic [1:0] md;
        logic [7:0] tv;
        md = 2'($urandom_range(0, 3));
        tv = ($urandom_range(0, 1) == 1) ? m_q + 8'($urandom_range(0, 24))
                                          : m_q - 8'($urandom_range(0, 24));
        tick(1'b1, md, 8'($urandom), tv, 1'b0);
        for (int k = 0; k < 300; k++) begin
          if (m_phase == P_IDLE) break;
          tick(($urandom_range(0, 3) == 0), 2'($urandom), 8'($urandom), 8'($urandom),
               ($urandom_range(0, 23) == 0));
        end
        check("rnd_budget", m_phase == P_IDLE, 1'b1);
        idle_tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
